// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg: shared states, instruction bit indices and flush-depth helper
package mac_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WLOAD, WFLUSH, EXEC, DRAIN, DONE} state_t;
  localparam int INST_LOAD = 0;
  localparam int INST_EXEC = 1;
  function automatic int flush_len(input int r, input int c);
    return r + c - 1;
  endfunction
endpackage

// File: rtl/mac_ctrl_phase_cnt.sv
// mac_ctrl_phase_cnt: loadable down-counter with terminal-count flag
module mac_ctrl_phase_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  // count down to zero, restart on load
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= ld_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign tc = cnt == '0;
endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: systolic MAC array tile sequencer (optional MAC_ARRAY_CTRL_PERF_EN adds perf_cycles)
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_bw  = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  cfg_len,
  output logic               sram_rd,
  output logic [addr_bw-1:0] sram_addr,
  output logic               inst_load,
  output logic               inst_exec,
  output logic               mac_en,
  output logic               busy,
  output logic               done
`ifdef MAC_ARRAY_CTRL_PERF_EN
  ,
  output logic [15:0]        perf_cycles
`endif
);
  localparam int FLUSH = flush_len(row, col);
  localparam int CW = 16;
  state_t state, nxt;
  logic [len_bw-1:0] len;
  logic [1:0] inst, inst_n;
  logic ld, tc, rd_n, accept;
  logic [CW-1:0] ld_val;
  logic [addr_bw-1:0] addr_n;
  assign accept = state == IDLE && start;
  mac_ctrl_phase_cnt #(.W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (ld),
    .ld_val(ld_val),
    .tc    (tc)
  );
  // next state, phase-counter reload and next registered outputs
  always_comb begin
    nxt = state;
    ld = 1'b0;
    ld_val = '0;
    case (state)
      IDLE: if (start) begin
        nxt = cfg_len != '0 ? WLOAD : DONE;
        ld = 1'b1;
        ld_val = CW'(col - 1);
      end
      WLOAD: if (tc) begin
        nxt = WFLUSH;
        ld = 1'b1;
        ld_val = CW'(FLUSH - 1);
      end
      WFLUSH: if (tc) begin
        nxt = EXEC;
        ld = 1'b1;
        ld_val = CW'(len) - CW'(1);
      end
      EXEC: if (tc) begin
        nxt = DRAIN;
        ld = 1'b1;
        ld_val = CW'(FLUSH - 1);
      end
      DRAIN: nxt = tc ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
    rd_n = nxt == WLOAD || nxt == EXEC;
    addr_n = nxt == WLOAD ? (state == WLOAD ? sram_addr + addr_bw'(1) : '0) :
             nxt == EXEC  ? (state == EXEC ? sram_addr + addr_bw'(1) : addr_bw'(col)) : '0;
    inst_n = '0;
    inst_n[INST_LOAD] = sram_rd && state == WLOAD;
    inst_n[INST_EXEC] = sram_rd && state == EXEC;
  end
  // state and registered outputs; instructions trail the read enable by the SRAM latency
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      len <= '0;
      sram_rd <= 1'b0;
      sram_addr <= '0;
      inst <= '0;
      mac_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) len <= cfg_len;
      sram_rd <= rd_n;
      sram_addr <= addr_n;
      inst <= inst_n;
      mac_en <= inst_n[INST_EXEC] || nxt == DRAIN;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
    end
  assign inst_load = inst[INST_LOAD];
  assign inst_exec = inst[INST_EXEC];
`ifdef MAC_ARRAY_CTRL_PERF_EN
  // busy-cycle counter, saturating, cleared on each accepted start
  always_ff @(posedge clk)
    if (reset) perf_cycles <= '0;
    else if (accept) perf_cycles <= '0;
    else if (busy && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
`endif
endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb_mac_array_ctrl: directed scoreboard bench for mac_array_ctrl
module tb_mac_array_ctrl;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int FL = ROW + COL - 1;
  localparam int AW = 11;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] cfg_len = '0;
  logic sram_rd, inst_load, inst_exec, mac_en, busy, done;
  logic [AW-1:0] sram_addr;
  logic [16:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [15:0] perf_cycles;
`endif
  mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(8), .addr_bw(AW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cfg_len(cfg_len),
    .sram_rd(sram_rd),
    .sram_addr(sram_addr),
    .inst_load(inst_load),
    .inst_exec(inst_exec),
    .mac_en(mac_en),
    .busy(busy),
    .done(done)
`ifdef MAC_ARRAY_CTRL_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );
  always #5 clk = ~clk;
  // expected {busy,done,mac_en,inst_exec,inst_load,sram_rd,sram_addr} k cycles after the accepting edge
  function automatic logic [16:0] exp_vec(input int len, input int k);
    int e0, e1, t;
    logic rd, ld, ex, mac;
    logic [AW-1:0] a;
    if (len == 0) return k == 1 ? {2'b11, 15'd0} : 17'd0;
    e0 = COL + FL + 1;
    e1 = e0 + len - 1;
    t = e1 + FL + 1;
    rd = (k >= 1 && k <= COL) || (k >= e0 && k <= e1);
    a = (k >= 1 && k <= COL) ? AW'(k - 1) : (k >= e0 && k <= e1) ? AW'(COL + k - e0) : '0;
    ld = k >= 2 && k <= COL + 1;
    ex = k >= e0 + 1 && k <= e1 + 1;
    mac = k >= e0 + 1 && k <= t - 1;
    return {k >= 1 && k <= t, k == t, mac, ex, ld, rd, a};
  endfunction
  function automatic int tile_len(input int len);
    return len == 0 ? 1 : COL + 2 * FL + len + 1;
  endfunction
  task automatic check(input string tag, input int k, input logic [16:0] e);
    logic [16:0] obs;
    obs = {busy, done, mac_en, inst_exec, inst_load, sram_rd, sram_addr};
    n_vec++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, e);
    end
  endtask
  // call at a negedge: drives start, pushes the whole expected tile, then checks each cycle
  task automatic tile(input string tag, input int len, input int extra_at, input bit start_in_done, input int abort_at);
    int t;
    logic [16:0] e;
    t = tile_len(len);
    start = 1'b1;
    cfg_len = 8'(len);
    for (int k = 1; k <= t + 1; k++) exp_q.push_back(exp_vec(len, k));
    for (int k = 1; k <= t + 1; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check(tag, k, e);
`ifdef MAC_ARRAY_CTRL_PERF_EN
      if (k == t + 1) begin
        n_vec++;
        assert (perf_cycles === 16'(t)) else begin
          n_err++;
          $error("FAIL %s_perf observed=%0d expected=%0d", tag, perf_cycles, t);
        end
      end
`endif
      start = (k == extra_at) || (start_in_done && k == t);
      if (k == extra_at) cfg_len = 8'd9;
      if (k == abort_at) begin
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check({tag, "_abort"}, k + 1, 17'd0);
        reset = 1'b0;
        return;
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset", i, 17'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("idle", 0, 17'd0);
    tile("len4_extra", 4, 10, 1'b1, 0);
    tile("b2b_len4", 4, 0, 1'b0, 0);
    tile("len0", 0, 0, 1'b0, 0);
    @(negedge clk);
    check("idle2", 0, 17'd0);
    tile("abort", 4, 0, 1'b0, 26);
    tile("len2", 2, 0, 1'b0, 0);
    tile("len255", 255, 0, 1'b0, 0);
    tile("len1", 1, 0, 1'b0, 0);
    @(negedge clk);
    check("idle3", 0, 17'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
